// File: rtl/placement_pkg.sv
// Shared types and constants for the placement wirelength evaluator.
// Optional 1-hop cost is enabled by defining PLACEMENT_COST_1HOP_EN.
package placement_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_EDGE,
        WT_EDGE,
        RD_A,
        WT_A,
        RD_B,
        WT_B,
        ACC,
        FIN
    } state_e;

    localparam logic signed [31:0] UNPLACED       = -32'sd1;
    localparam int                 DEFAULT_GRID_N = 10;
    localparam int                 DEFAULT_N_EDGE = 96;

    // The unsigned compare also rejects any other negative coordinate.
    function automatic logic coord_ok(input logic signed [31:0] c, input int grid_n);
        return (c != UNPLACED) && ($unsigned(c) < $unsigned(grid_n));
    endfunction

endpackage

// File: rtl/manhattan_term.sv
// Per-edge Manhattan cost |dx|+|dy|-1 and, when PLACEMENT_COST_1HOP_EN is
// defined, the 1-hop cost ceil(|dx|/2)+ceil(|dy|/2)-1; otherwise that is 0.
module manhattan_term (
    input  logic signed [31:0] ax,
    input  logic signed [31:0] ay,
    input  logic signed [31:0] bx,
    input  logic signed [31:0] by,
    output logic signed [31:0] term,
    output logic signed [31:0] term_1hop
);

    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] adx;
    logic [31:0] ady;

    always_comb begin
        dx   = ax - bx;
        dy   = ay - by;
        adx  = dx[31] ? (32'd0 - dx) : dx;
        ady  = dy[31] ? (32'd0 - dy) : dy;
        term = adx + ady - 32'd1;
    end

`ifdef PLACEMENT_COST_1HOP_EN
    assign term_1hop = ((adx >> 1) + {31'd0, adx[0]})
                     + ((ady >> 1) + {31'd0, ady[0]}) - 32'd1;
`else
    assign term_1hop = '0;
`endif

endmodule

// File: rtl/placement_cost_eval.sv
// Walks an edge list, fetches both endpoint positions and accumulates wirelength.
// sum_1hop is live only when PLACEMENT_COST_1HOP_EN is defined.
module placement_cost_eval
    import placement_pkg::*;
#(
    parameter int N_EDGE = DEFAULT_N_EDGE,
    parameter int GRID_N = DEFAULT_GRID_N,
    parameter int AW     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 ea_re,
    output logic                 eb_re,
    output logic [AW-1:0]        ea_addr,
    output logic [AW-1:0]        eb_addr,
    input  logic [31:0]          ea_data,
    input  logic [31:0]          eb_data,
    output logic                 px_re,
    output logic                 py_re,
    output logic [AW-1:0]        px_addr,
    output logic [AW-1:0]        py_addr,
    input  logic signed [31:0]   px_data,
    input  logic signed [31:0]   py_data,
    output logic signed [31:0]   sum,
    output logic signed [31:0]   sum_1hop,
    output logic [15:0]          err_cnt,
    output logic [31:0]          cycles
);

    state_e             state_q, state_d;
    logic [31:0]        i_q, i_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               e_re_q, e_re_d;
    logic [AW-1:0]      e_addr_q, e_addr_d;
    logic               p_re_q, p_re_d;
    logic [AW-1:0]      p_addr_q, p_addr_d;
    logic [31:0]        eb_node_q, eb_node_d;
    logic signed [31:0] ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d;
    logic signed [31:0] sum_q, sum_d, sum_1hop_q, sum_1hop_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic [31:0]        cycles_q, cycles_d;

    logic signed [31:0] term;
    logic signed [31:0] term_1hop;
    logic               edge_ok;

    manhattan_term u_term (
        .ax        (ax_q),
        .ay        (ay_q),
        .bx        (bx_q),
        .by        (by_q),
        .term      (term),
        .term_1hop (term_1hop)
    );

    assign edge_ok = coord_ok(ax_q, GRID_N) && coord_ok(ay_q, GRID_N)
                  && coord_ok(bx_q, GRID_N) && coord_ok(by_q, GRID_N);

    always_comb begin
        // NOTE: every _d starts from its hold value (or 0 for pulses) so no path infers a latch.
        state_d    = state_q;
        i_d        = i_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        e_re_d     = 1'b0;
        e_addr_d   = e_addr_q;
        p_re_d     = 1'b0;
        p_addr_d   = p_addr_q;
        eb_node_d  = eb_node_q;
        ax_d       = ax_q;
        ay_d       = ay_q;
        bx_d       = bx_q;
        by_d       = by_q;
        sum_d      = sum_q;
        sum_1hop_d = sum_1hop_q;
        err_cnt_d  = err_cnt_q;
        cycles_d   = cycles_q;

        if (state_q != IDLE && state_q != FIN) begin
            cycles_d = cycles_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RD_EDGE;
                    busy_d     = 1'b1;
                    i_d        = '0;
                    sum_d      = '0;
                    sum_1hop_d = '0;
                    err_cnt_d  = '0;
                    cycles_d   = 32'd1;
                    if (N_EDGE != 0) begin
                        e_re_d   = 1'b1;
                        e_addr_d = '0;
                    end
                end
            end
            // The edge-ROM read was already launched on entry to this state.
            RD_EDGE: begin
                if (i_q == 32'(N_EDGE)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = WT_EDGE;
                end
            end
            WT_EDGE: begin
                state_d   = RD_A;
                p_re_d    = 1'b1;
                p_addr_d  = AW'(ea_data);
                eb_node_d = eb_data;
            end
            RD_A: state_d = WT_A;
            WT_A: begin
                state_d  = RD_B;
                ax_d     = px_data;
                ay_d     = py_data;
                p_re_d   = 1'b1;
                p_addr_d = AW'(eb_node_q);
            end
            RD_B: state_d = WT_B;
            WT_B: begin
                state_d = ACC;
                bx_d    = px_data;
                by_d    = py_data;
            end
            ACC: begin
                state_d = RD_EDGE;
                i_d     = i_q + 32'd1;
                if (edge_ok) begin
                    sum_d      = sum_q + term;
                    sum_1hop_d = sum_1hop_q + term_1hop;
                end else if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
                if (i_q + 32'd1 != 32'(N_EDGE)) begin
                    e_re_d   = 1'b1;
                    e_addr_d = AW'(i_q + 32'd1);
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            i_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            e_re_q     <= 1'b0;
            e_addr_q   <= '0;
            p_re_q     <= 1'b0;
            p_addr_q   <= '0;
            eb_node_q  <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            sum_q      <= '0;
            sum_1hop_q <= '0;
            err_cnt_q  <= '0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            e_re_q     <= e_re_d;
            e_addr_q   <= e_addr_d;
            p_re_q     <= p_re_d;
            p_addr_q   <= p_addr_d;
            eb_node_q  <= eb_node_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            sum_q      <= sum_d;
            sum_1hop_q <= sum_1hop_d;
            err_cnt_q  <= err_cnt_d;
            cycles_q   <= cycles_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ea_re    = e_re_q;
    assign eb_re    = e_re_q;
    assign ea_addr  = e_addr_q;
    assign eb_addr  = e_addr_q;
    assign px_re    = p_re_q;
    assign py_re    = p_re_q;
    assign px_addr  = p_addr_q;
    assign py_addr  = p_addr_q;
    assign sum      = sum_q;
    assign sum_1hop = sum_1hop_q;
    assign err_cnt  = err_cnt_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_placement_cost_eval.sv
// Bench for placement_cost_eval: five instances (N_EDGE 96/1/2/3/0) sharing
// behavioural ROM/RAM models, directed cases plus randomized placements.
module tb_placement_cost_eval;

    localparam int GRID_N = 10;
    localparam int NI     = 5;

    function automatic int ne_of(input int g);
        case (g)
            0:       return 96;
            1:       return 1;
            2:       return 2;
            3:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int hop(input int v);
`ifdef PLACEMENT_COST_1HOP_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic               start_v   [NI];
    logic               busy_v    [NI];
    logic               done_v    [NI];
    logic               ea_re_v   [NI];
    logic               eb_re_v   [NI];
    logic               px_re_v   [NI];
    logic               py_re_v   [NI];
    logic [31:0]        ea_addr_v [NI];
    logic [31:0]        eb_addr_v [NI];
    logic [31:0]        px_addr_v [NI];
    logic [31:0]        py_addr_v [NI];
    logic [31:0]        ea_data_v [NI];
    logic [31:0]        eb_data_v [NI];
    logic signed [31:0] px_data_v [NI];
    logic signed [31:0] py_data_v [NI];
    logic signed [31:0] sum_v     [NI];
    logic signed [31:0] sum1_v    [NI];
    logic [15:0]        err_v     [NI];
    logic [31:0]        cyc_v     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        placement_cost_eval #(
            .N_EDGE (ne_of(g)),
            .GRID_N (GRID_N),
            .AW     (32)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .ea_re    (ea_re_v[g]),
            .eb_re    (eb_re_v[g]),
            .ea_addr  (ea_addr_v[g]),
            .eb_addr  (eb_addr_v[g]),
            .ea_data  (ea_data_v[g]),
            .eb_data  (eb_data_v[g]),
            .px_re    (px_re_v[g]),
            .py_re    (py_re_v[g]),
            .px_addr  (px_addr_v[g]),
            .py_addr  (py_addr_v[g]),
            .px_data  (px_data_v[g]),
            .py_data  (py_data_v[g]),
            .sum      (sum_v[g]),
            .sum_1hop (sum1_v[g]),
            .err_cnt  (err_v[g]),
            .cycles   (cyc_v[g])
        );
    end

    logic [31:0]        ea_rom [128];
    logic [31:0]        eb_rom [128];
    logic signed [31:0] px_mem [64];
    logic signed [31:0] py_mem [64];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ea_rd    [NI];
    int   px_rd    [NI];
    int   done_cnt [NI];
    int   re_viol  = 0;
    logic prev_ea  [NI];
    logic prev_px  [NI];

    // Memories return data only the cycle after a read enable; garbage otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            ea_data_v[k] <= ea_re_v[k] ? ea_rom[ea_addr_v[k][6:0]] : $urandom();
            eb_data_v[k] <= eb_re_v[k] ? eb_rom[eb_addr_v[k][6:0]] : $urandom();
            px_data_v[k] <= px_re_v[k] ? px_mem[px_addr_v[k][5:0]] : $urandom();
            py_data_v[k] <= py_re_v[k] ? py_mem[py_addr_v[k][5:0]] : $urandom();
            if (ea_re_v[k] === 1'b1) ea_rd[k] <= ea_rd[k] + 1;
            if (px_re_v[k] === 1'b1) px_rd[k] <= px_rd[k] + 1;
            if (done_v[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
            if ((ea_re_v[k] === 1'b1 && prev_ea[k] === 1'b1) ||
                (px_re_v[k] === 1'b1 && prev_px[k] === 1'b1) ||
                (ea_re_v[k] !== eb_re_v[k]) || (px_re_v[k] !== py_re_v[k]) ||
                (ea_re_v[k] === 1'b1 && ea_addr_v[k] !== eb_addr_v[k]) ||
                (px_re_v[k] === 1'b1 && px_addr_v[k] !== py_addr_v[k]))
                re_viol <= re_viol + 1;
            prev_ea[k] <= ea_re_v[k];
            prev_px[k] <= px_re_v[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic logic signed [31:0] rnd_coord();
        int r;
        r = $urandom_range(0, 99);
        if (r < 5) return -1;
        if (r < 9) return GRID_N + $urandom_range(0, 2);
        return $urandom_range(0, GRID_N - 1);
    endfunction

    task automatic load_random();
        for (int k = 0; k < 128; k++) begin
            ea_rom[k] = $urandom_range(0, 31);
            eb_rom[k] = (k % 13 == 5) ? ea_rom[k] : $urandom_range(0, 31);
        end
        for (int k = 0; k < 64; k++) begin
            px_mem[k] = rnd_coord();
            py_mem[k] = rnd_coord();
        end
    endtask

    // Reference: straight from the cost definition, no notion of states or timing.
    task automatic model(input int n, output int s, output int s1, output int e);
        s = 0; s1 = 0; e = 0;
        for (int k = 0; k < n; k++) begin
            int c[4];
            bit bad;
            int dx, dy;
            c[0] = px_mem[ea_rom[k]]; c[1] = py_mem[ea_rom[k]];
            c[2] = px_mem[eb_rom[k]]; c[3] = py_mem[eb_rom[k]];
            bad = 1'b0;
            for (int j = 0; j < 4; j++) if (c[j] < 0 || c[j] >= GRID_N) bad = 1'b1;
            if (bad) begin
                if (e < 65535) e++;
            end else begin
                dx = (c[0] > c[2]) ? c[0] - c[2] : c[2] - c[0];
                dy = (c[1] > c[3]) ? c[1] - c[3] : c[3] - c[1];
                s  += dx + dy - 1;
                s1 += (dx + 1) / 2 + (dy + 1) / 2 - 1;
            end
        end
        s1 = hop(s1);
    endtask

    task automatic run(input string tag, input int id, input bit poke_busy, input bit poke_done,
                       input int exp_sum, input int exp_1h, input int exp_err);
        int n, lat, cyc, ea0, px0, d0;
        n   = ne_of(id);
        lat = 7 * n + 2;
        @(posedge clk); #1;
        ea0 = ea_rd[id]; px0 = px_rd[id]; d0 = done_cnt[id];
        start_v[id] = 1'b1;
        @(posedge clk); #1;
        start_v[id] = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, 32'(busy_v[id]), 32'd1);
        while (done_v[id] !== 1'b1 && cyc < lat + 16) begin
            start_v[id] = poke_busy && (cyc == 4);
            @(posedge clk); #1;
            cyc++;
        end
        start_v[id] = 1'b0;
        check({tag, "_done"},    32'(done_v[id]), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_cycles"},  cyc_v[id], 32'(lat));
        check({tag, "_sum"},     sum_v[id], 32'(exp_sum));
        check({tag, "_sum1hop"}, sum1_v[id], 32'(exp_1h));
        check({tag, "_err"},     32'(err_v[id]), 32'(exp_err));
        check({tag, "_edge_rd"}, 32'(ea_rd[id] - ea0), 32'(n));
        check({tag, "_pos_rd"},  32'(px_rd[id] - px0), 32'(2 * n));
        start_v[id] = poke_done;
        @(posedge clk); #1;
        start_v[id] = 1'b0;
        check({tag, "_done_pulse"}, 32'(done_v[id]), 32'd0);
        check({tag, "_idle"},       32'(busy_v[id]), 32'd0);
        check({tag, "_sum_hold"},   sum_v[id], 32'(exp_sum));
        check({tag, "_cyc_hold"},   cyc_v[id], 32'(lat));
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_stay_idle"}, 32'(busy_v[id]), 32'd0);
        check({tag, "_n_done"},    32'(done_cnt[id] - d0), 32'd1);
    endtask

    initial begin
        int s, s1, e, cyc, d0;
        for (int g = 0; g < NI; g++) start_v[g] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_busy%0d", g),  32'(busy_v[g]), 32'd0);
            check($sformatf("rst_done%0d", g),  32'(done_v[g]), 32'd0);
            check($sformatf("rst_sum%0d", g),   sum_v[g], 32'd0);
            check($sformatf("rst_err%0d", g),   32'(err_v[g]), 32'd0);
            check($sformatf("rst_cyc%0d", g),   cyc_v[g], 32'd0);
            check($sformatf("rst_re%0d", g),    32'(ea_re_v[g]) | 32'(px_re_v[g]), 32'd0);
        end

        // One edge, (0,0) -> (3,4).
        ea_rom[0] = 0; eb_rom[0] = 1;
        px_mem[0] = 0; py_mem[0] = 0; px_mem[1] = 3; py_mem[1] = 4;
        run("one_edge", 1, 1'b0, 1'b0, 6, hop(3), 0);
        run("start_pokes", 1, 1'b1, 1'b1, 6, hop(3), 0);

        // Adjacent chain: every edge costs zero.
        ea_rom[0] = 0; eb_rom[0] = 1; ea_rom[1] = 1; eb_rom[1] = 2;
        px_mem[1] = 1; py_mem[1] = 0; px_mem[2] = 1; py_mem[2] = 1;
        run("chain", 2, 1'b0, 1'b0, 0, hop(0), 0);

        // Node 1 unplaced on one of three edges.
        ea_rom[0] = 0; eb_rom[0] = 2; ea_rom[1] = 2; eb_rom[1] = 3; ea_rom[2] = 1; eb_rom[2] = 3;
        px_mem[1] = -1; py_mem[1] = 4; px_mem[2] = 2; py_mem[2] = 0; px_mem[3] = 2; py_mem[3] = 5;
        run("unplaced", 3, 1'b0, 1'b0, 5, hop(2), 1);

        run("no_edges", 4, 1'b0, 1'b0, 0, 0, 0);

        for (int r = 0; r < 3; r++) begin
            load_random();
            model(96, s, s1, e);
            run($sformatf("rand%0d", r), 0, r == 1, r == 2, s, s1, e);
        end

        // Abort a run mid-flight, then a fresh run must complete normally.
        load_random();
        model(96, s, s1, e);
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        cyc = 1;
        d0 = done_cnt[0];
        while (cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy",  32'(busy_v[0]), 32'd0);
        check("abort_done",  32'(done_v[0]), 32'd0);
        check("abort_sum",   sum_v[0], 32'd0);
        check("abort_1hop",  sum1_v[0], 32'd0);
        check("abort_err",   32'(err_v[0]), 32'd0);
        check("abort_cyc",   cyc_v[0], 32'd0);
        check("abort_re",    32'(ea_re_v[0]) | 32'(px_re_v[0]), 32'd0);
        check("abort_eaddr", ea_addr_v[0], 32'd0);
        check("abort_paddr", px_addr_v[0], 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
        check("abort_idle",    32'(busy_v[0]), 32'd0);
        run("after_abort", 0, 1'b0, 1'b0, s, s1, e);

        check("read_protocol", 32'(re_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
